// File: rtl/hsv_core_pkg.sv
// Shared types for the HSV core load/store unit.
// Counter, bus word, token and read-metadata definitions.
package hsv_core_pkg;

  localparam int MEM_COUNTER_BITS = 8;

  typedef logic signed [MEM_COUNTER_BITS-1:0] mem_counter;
  typedef logic [31:0] word;
  typedef logic [5:0]  insn_token;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef struct packed {
    insn_token  token;
    mem_size_t  size;
    logic       sign_ext;
    logic [1:0] offset;
  } mem_read_meta_t;

endpackage

// File: rtl/hsv_core_mem_meta_fifo.sv
// Read-metadata FIFO with a broadcast kill of all queued entries.
// Pointers carry one extra wrap bit to tell full from empty.
module hsv_core_mem_meta_fifo
  import hsv_core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  mem_read_meta_t push_data,
  input  logic           pop,
  input  logic           kill,
  output mem_read_meta_t head,
  output logic           head_killed,
  output logic           empty,
  output logic           full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  mem_read_meta_t   r_mem [DEPTH];
  logic [DEPTH-1:0] r_killed;

  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW])
              && (w_wr_idx == w_rd_idx);

  assign head        = r_mem[w_rd_idx];
  assign head_killed = r_killed[w_rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_killed <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (kill) begin
        r_killed <= '1;
      end
      // A same-cycle push inherits the kill.
      if (push) begin
        r_mem[w_wr_idx]    <= push_data;
        r_killed[w_wr_idx] <= kill;
        r_wr_ptr           <= r_wr_ptr + 1'b1;
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  a_no_overflow : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && full && !pop));

  a_no_underflow : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(pop && empty));

endmodule

// File: rtl/hsv_core_mem_response.sv
// HSV core memory response stage: bus counters, load alignment.
// HSV_CORE_MEM_BUS_ERROR_EN enables R/B error reporting.
module hsv_core_mem_response
  import hsv_core_pkg::*;
#(
  parameter int META_DEPTH = 4
) (
  input  logic           clk_core,
  input  logic           rst_core_n,
  input  logic           flush,
  input  logic           pending_reads_up,
  input  mem_read_meta_t read_meta,
  input  logic           pending_writes_up,
  input  logic           write_balance_down,
  input  logic           commit_write_up,
  output mem_counter     pending_reads,
  output mem_counter     pending_writes,
  output mem_counter     write_balance,
  output logic           fence_ready,
  output logic           meta_full,
  input  logic           dmem_r_valid,
  input  word            dmem_r_data,
  input  logic [1:0]     dmem_r_resp,
  output logic           dmem_r_ready,
  input  logic           dmem_b_valid,
  input  logic [1:0]     dmem_b_resp,
  output logic           dmem_b_ready,
  output logic           valid_o,
  output word            result,
  output insn_token      result_token,
  output logic           fault,
  input  logic           stall_i,
  output logic           write_fault
);

  mem_counter r_pending_reads;
  mem_counter r_pending_writes;
  mem_counter r_write_balance;
  logic       r_valid;
  word        r_result;
  insn_token  r_token;

  mem_read_meta_t w_head;
  logic           w_head_killed;
  logic           w_empty;
  logic           w_r_hs;
  logic           w_b_hs;
  word            w_shifted;
  word            w_load;

  assign dmem_r_ready = ~r_valid | ~stall_i;
  assign dmem_b_ready = 1'b1;
  assign w_r_hs = dmem_r_valid & dmem_r_ready;
  assign w_b_hs = dmem_b_valid & dmem_b_ready;

  hsv_core_mem_meta_fifo #(
    .DEPTH (META_DEPTH)
  ) u_meta_fifo (
    .clk         (clk_core),
    .rst_n       (rst_core_n),
    .push        (pending_reads_up),
    .push_data   (read_meta),
    .pop         (w_r_hs),
    .kill        (flush),
    .head        (w_head),
    .head_killed (w_head_killed),
    .empty       (w_empty),
    .full        (meta_full)
  );

  always_comb begin
    w_shifted = dmem_r_data >> {w_head.offset, 3'b000};
    w_load    = w_shifted;
    unique case (w_head.size)
      BYTE: w_load = {{24{w_head.sign_ext & w_shifted[7]}},
                      w_shifted[7:0]};
      HALF: w_load = {{16{w_head.sign_ext & w_shifted[15]}},
                      w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_pending_reads  <= '0;
      r_pending_writes <= '0;
      r_write_balance  <= '0;
    end else begin
      r_pending_reads  <= r_pending_reads
                        + mem_counter'(pending_reads_up)
                        - mem_counter'(w_r_hs);
      r_pending_writes <= r_pending_writes
                        + mem_counter'(pending_writes_up)
                        - mem_counter'(w_b_hs);
      r_write_balance  <= r_write_balance
                        + mem_counter'(commit_write_up)
                        - mem_counter'(write_balance_down);
    end
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_token  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_r_hs && !w_head_killed) begin
      r_valid  <= 1'b1;
      r_result <= w_load;
      r_token  <= w_head.token;
    end else if (!stall_i) begin
      r_valid <= 1'b0;
    end
  end

`ifdef HSV_CORE_MEM_BUS_ERROR_EN
  logic r_fault;
  logic r_write_fault;

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_fault       <= 1'b0;
      r_write_fault <= 1'b0;
    end else begin
      if (!flush && w_r_hs && !w_head_killed) begin
        r_fault <= (dmem_r_resp != 2'b00);
      end
      r_write_fault <= w_b_hs && (dmem_b_resp != 2'b00);
    end
  end

  assign fault       = r_fault;
  assign write_fault = r_write_fault;
`else
  logic w_unused;
  assign w_unused    = ^{dmem_r_resp, dmem_b_resp, w_empty};
  assign fault       = 1'b0;
  assign write_fault = 1'b0;
`endif

`ifdef HSV_CORE_MEM_BUS_ERROR_EN
  logic w_unused_empty;
  assign w_unused_empty = w_empty;
`endif

  assign pending_reads  = r_pending_reads;
  assign pending_writes = r_pending_writes;
  assign write_balance  = r_write_balance;
  assign valid_o        = r_valid;
  assign result         = r_result;
  assign result_token   = r_token;
  assign fence_ready    = (r_pending_reads == '0)
                        & (r_pending_writes == '0)
                        & ~r_valid;

endmodule

// File: tb/tb_hsv_core_mem_response.sv
// Directed bench for hsv_core_mem_response: alignment table
// plus hand-written counter, flush, stall and error sequences.
module tb_hsv_core_mem_response;
  import hsv_core_pkg::*;

  logic           clk_core = 1'b0;
  logic           rst_core_n;
  logic           flush;
  logic           pending_reads_up;
  mem_read_meta_t read_meta;
  logic           pending_writes_up;
  logic           write_balance_down;
  logic           commit_write_up;
  mem_counter     pending_reads;
  mem_counter     pending_writes;
  mem_counter     write_balance;
  logic           fence_ready;
  logic           meta_full;
  logic           dmem_r_valid;
  word            dmem_r_data;
  logic [1:0]     dmem_r_resp;
  logic           dmem_r_ready;
  logic           dmem_b_valid;
  logic [1:0]     dmem_b_resp;
  logic           dmem_b_ready;
  logic           valid_o;
  word            result;
  insn_token      result_token;
  logic           fault;
  logic           stall_i;
  logic           write_fault;

  int checks = 0;
  int failures = 0;

`ifdef HSV_CORE_MEM_BUS_ERROR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  always #5 clk_core = ~clk_core;

  hsv_core_mem_response #(
    .META_DEPTH (4)
  ) dut (
    .clk_core           (clk_core),
    .rst_core_n         (rst_core_n),
    .flush              (flush),
    .pending_reads_up   (pending_reads_up),
    .read_meta          (read_meta),
    .pending_writes_up  (pending_writes_up),
    .write_balance_down (write_balance_down),
    .commit_write_up    (commit_write_up),
    .pending_reads      (pending_reads),
    .pending_writes     (pending_writes),
    .write_balance      (write_balance),
    .fence_ready        (fence_ready),
    .meta_full          (meta_full),
    .dmem_r_valid       (dmem_r_valid),
    .dmem_r_data        (dmem_r_data),
    .dmem_r_resp        (dmem_r_resp),
    .dmem_r_ready       (dmem_r_ready),
    .dmem_b_valid       (dmem_b_valid),
    .dmem_b_resp        (dmem_b_resp),
    .dmem_b_ready       (dmem_b_ready),
    .valid_o            (valid_o),
    .result             (result),
    .result_token       (result_token),
    .fault              (fault),
    .stall_i            (stall_i),
    .write_fault        (write_fault)
  );

  typedef struct {
    mem_size_t  size;
    logic       sgn;
    logic [1:0] off;
    word        data;
    word        exp;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic issue(input insn_token tok,
                       input mem_size_t sz,
                       input logic sg,
                       input logic [1:0] off);
    pending_reads_up = 1'b1;
    read_meta = '{token: tok, size: sz,
                  sign_ext: sg, offset: off};
    tick();
    pending_reads_up = 1'b0;
  endtask

  task automatic beat(input word d, input logic [1:0] rs);
    dmem_r_valid = 1'b1;
    dmem_r_data  = d;
    dmem_r_resp  = rs;
    tick();
    dmem_r_valid = 1'b0;
    dmem_r_resp  = 2'b00;
  endtask

  initial begin
    vecs[0] = '{BYTE, 1'b1, 2'd3, 32'h80112233, 32'hFFFFFF80};
    vecs[1] = '{BYTE, 1'b0, 2'd3, 32'h80112233, 32'h00000080};
    vecs[2] = '{BYTE, 1'b1, 2'd0, 32'h80112233, 32'h00000033};
    vecs[3] = '{HALF, 1'b1, 2'd2, 32'h80112233, 32'hFFFF8011};
    vecs[4] = '{HALF, 1'b0, 2'd0, 32'h0000F234, 32'h0000F234};
    vecs[5] = '{HALF, 1'b1, 2'd0, 32'h0000F234, 32'hFFFFF234};
    vecs[6] = '{WORD, 1'b1, 2'd0, 32'h80112233, 32'h80112233};
    vecs[7] = '{BYTE, 1'b1, 2'd1, 32'h0000A500, 32'hFFFFFFA5};
    vecs[8] = '{BYTE, 1'b0, 2'd2, 32'h00FF0000, 32'h000000FF};

    rst_core_n = 1'b0;
    flush = 1'b0;
    pending_reads_up = 1'b0;
    read_meta = '0;
    pending_writes_up = 1'b0;
    write_balance_down = 1'b0;
    commit_write_up = 1'b0;
    dmem_r_valid = 1'b0;
    dmem_r_data = '0;
    dmem_r_resp = 2'b00;
    dmem_b_valid = 1'b0;
    dmem_b_resp = 2'b00;
    stall_i = 1'b0;
    tick();
    tick();
    rst_core_n = 1'b1;
    tick();

    chk("rst_preads", int'(pending_reads), 0);
    chk("rst_pwrites", int'(pending_writes), 0);
    chk("rst_wbal", int'(write_balance), 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_fault", fault, 0);
    chk("rst_wfault", write_fault, 0);
    chk("rst_full", meta_full, 0);
    chk("rst_rready", dmem_r_ready, 1);
    chk("rst_bready", dmem_b_ready, 1);
    chk("rst_fence", fence_ready, 1);

    for (int i = 1; i <= 3; i++) issue(insn_token'(i), WORD, 1'b0, 2'd0);
    chk("r3_preads", int'(pending_reads), 3);
    chk("r3_fence", fence_ready, 0);
    chk("r3_full", meta_full, 0);
    issue(6'd4, WORD, 1'b0, 2'd0);
    chk("r4_full", meta_full, 1);
    for (int i = 1; i <= 4; i++) begin
      beat(32'h1000 + i, 2'b00);
      chk("burst_valid", valid_o, 1);
      chk("burst_tok", result_token, i);
      chk("burst_data", result, 32'h1000 + i);
    end
    chk("burst_preads", int'(pending_reads), 0);
    chk("burst_fence_busy", fence_ready, 0);
    tick();
    chk("burst_drain", valid_o, 0);
    chk("burst_fence", fence_ready, 1);

    for (int i = 0; i < 9; i++) begin
      issue(insn_token'(8 + i), vecs[i].size, vecs[i].sgn, vecs[i].off);
      beat(vecs[i].data, 2'b00);
      chk("align_valid", valid_o, 1);
      chk("align_res", result, vecs[i].exp);
      chk("align_tok", result_token, 8 + i);
      chk("align_fault", fault, 0);
      tick();
    end

    issue(6'd20, WORD, 1'b0, 2'd0);
    issue(6'd21, WORD, 1'b0, 2'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_preads2", int'(pending_reads), 2);
    beat(32'hDEAD0001, 2'b00);
    chk("fl_valid1", valid_o, 0);
    chk("fl_preads1", int'(pending_reads), 1);
    beat(32'hDEAD0002, 2'b00);
    chk("fl_valid2", valid_o, 0);
    chk("fl_preads0", int'(pending_reads), 0);
    chk("fl_fence", fence_ready, 1);

    flush = 1'b1;
    issue(6'd22, WORD, 1'b0, 2'd0);
    flush = 1'b0;
    beat(32'hDEAD0003, 2'b00);
    chk("flpush_valid", valid_o, 0);
    issue(6'd23, WORD, 1'b0, 2'd0);
    beat(32'h00000023, 2'b00);
    chk("flrec_valid", valid_o, 1);
    chk("flrec_tok", result_token, 23);
    tick();

    issue(6'd30, WORD, 1'b0, 2'd0);
    issue(6'd31, WORD, 1'b0, 2'd0);
    beat(32'hAAAA0030, 2'b00);
    stall_i = 1'b1;
    dmem_r_valid = 1'b1;
    dmem_r_data = 32'hBBBB0031;
    #1;
    chk("st_rready0", dmem_r_ready, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("st_valid", valid_o, 1);
      chk("st_res", result, 32'hAAAA0030);
      chk("st_tok", result_token, 30);
      chk("st_preads", int'(pending_reads), 1);
    end
    stall_i = 1'b0;
    #1;
    chk("st_rready1", dmem_r_ready, 1);
    tick();
    dmem_r_valid = 1'b0;
    chk("st_res2", result, 32'hBBBB0031);
    chk("st_tok2", result_token, 31);
    chk("st_preads0", int'(pending_reads), 0);
    tick();
    chk("st_drain", valid_o, 0);

    issue(6'd40, WORD, 1'b0, 2'd0);
    beat(32'h00000040, 2'b10);
    chk("rfault", fault, ERR_EN);
    tick();

    commit_write_up = 1'b1;
    write_balance_down = 1'b1;
    tick();
    chk("wb_both", int'(write_balance), 0);
    commit_write_up = 1'b0;
    tick();
    chk("wb_down", int'(write_balance), -1);
    write_balance_down = 1'b0;
    commit_write_up = 1'b1;
    tick();
    chk("wb_up0", int'(write_balance), 0);
    tick();
    chk("wb_up1", int'(write_balance), 1);
    write_balance_down = 1'b1;
    tick();
    chk("wb_both1", int'(write_balance), 1);
    commit_write_up = 1'b0;
    write_balance_down = 1'b0;

    pending_writes_up = 1'b1;
    tick();
    chk("pw_1", int'(pending_writes), 1);
    chk("pw_fence", fence_ready, 0);
    dmem_b_valid = 1'b1;
    tick();
    chk("pw_same", int'(pending_writes), 1);
    pending_writes_up = 1'b0;
    dmem_b_resp = 2'b10;
    tick();
    dmem_b_valid = 1'b0;
    dmem_b_resp = 2'b00;
    chk("pw_dec", int'(pending_writes), 0);
    chk("wf_pulse", write_fault, ERR_EN);
    tick();
    chk("wf_clear", write_fault, 0);
    chk("pw_fence1", fence_ready, 1);

    issue(6'd50, WORD, 1'b0, 2'd0);
    pending_writes_up = 1'b1;
    tick();
    pending_writes_up = 1'b0;
    rst_core_n = 1'b0;
    #1;
    chk("mr_preads", int'(pending_reads), 0);
    chk("mr_pwrites", int'(pending_writes), 0);
    chk("mr_fence", fence_ready, 1);
    tick();
    rst_core_n = 1'b1;
    tick();
    issue(6'd51, HALF, 1'b1, 2'd2);
    beat(32'hC0DE0000, 2'b00);
    chk("mr_res", result, 32'hFFFFC0DE);
    chk("mr_tok", result_token, 51);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
